// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, FSM encoding,
// default watchdog limit and an index-width helper.
// Latency: n/a (package). Backpressure: n/a (package).
package uart_tx_arbiter_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEFAULT_MAX_GAP = 4800;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping N-1 -> 0.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: req_i (request vector), ptr_i (search start), pick_oh_o / pick_idx_o
//        (winner as one-hot and index), found_o (any request present).
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     pick_oh_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             found_o
);

  int               idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    found_o    = 1'b0;
    idx        = 0;
    sel        = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      sel = IDX_W'(idx);
      if (!found_o && req_i[sel]) begin
        found_o        = 1'b1;
        pick_oh_o[sel] = 1'b1;
        pick_idx_o     = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one rs232out transmitter between N byte-stream requesters with
// round-robin, message-atomic grants and a stall watchdog on the owner.
// Latency: 1 cycle arbitration per message, 1 cycle byte accept -> tx_valid_o;
// backpressure: owner req_ready_o follows the single-entry holding register
// (free when empty or draining), so back-to-back bytes flow without bubbles.
// Ports: clk48_i/rst_i (sync active-high), req_valid_i/req_data_i/req_last_i/
//        req_ready_o per requester, tx_valid_o/tx_data_o/tx_ready_i to rs232out,
//        grant_o (one-hot owner), busy_o (owner present or byte pending).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N       = 3,
  parameter int MAX_GAP = DEFAULT_MAX_GAP
) (
  input  logic                clk48_i,
  input  logic                rst_i,
  input  logic [N-1:0]        req_valid_i,
  input  logic [BYTE_W*N-1:0] req_data_i,
  input  logic [N-1:0]        req_last_i,
  output logic [N-1:0]        req_ready_o,
  output logic                tx_valid_o,
  output logic [BYTE_W-1:0]   tx_data_o,
  input  logic                tx_ready_i,
  output logic [N-1:0]        grant_o,
  output logic                busy_o
);

  localparam int IDX_W = idx_width(N);
  localparam int GAP_W = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LIMIT = (MAX_GAP > 0) ? GAP_W'(MAX_GAP - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  arb_state_e        state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]  owner_idx_q, owner_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;

  logic [N-1:0]      pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  logic              slot_free;
  logic              owner_vld;
  logic              owner_last;
  logic              accept;
  logic              wd_revoke;
  logic              release_owner;
  logic [BYTE_W-1:0] owner_data;

  uart_tx_arbiter_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i      (req_valid_i),
    .ptr_i      (rr_ptr_q),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx),
    .found_o    (pick_found)
  );

  // Holding register can take a byte if empty or if rs232out drains it this cycle.
  assign slot_free  = !tx_valid_q || tx_ready_i;
  assign owner_vld  = |(req_valid_i & grant_q);
  assign owner_last = |(req_last_i & grant_q);
  assign accept     = |(req_valid_i & req_ready_o);

  // Only a silent owner counts towards the watchdog; owner valid held against
  // a busy UART clears the counter instead.
  assign wd_revoke     = (MAX_GAP != 0) && (state_q == ST_OWN) && !owner_vld &&
                         (gap_q == GAP_LIMIT);
  assign release_owner = (accept && owner_last) || wd_revoke;

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) owner_data = req_data_i[BYTE_W*i +: BYTE_W];
    end
  end

  // FSM: state register
  always_ff @(posedge clk48_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_found)    state_d = ST_OWN;
      ST_OWN:  if (release_owner) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Ready only ever goes to the registered owner.
  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_OWN) req_ready_o = grant_q & {N{slot_free}};
  end

  // Grant, round-robin pointer, watchdog and holding register next state.
  always_comb begin
    grant_d     = grant_q;
    owner_idx_d = owner_idx_q;
    rr_ptr_d    = rr_ptr_q;
    gap_d       = gap_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;

    // Reload wins over drain when both happen in one cycle.
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = owner_data;
    end else if (tx_ready_i) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d     = pick_oh;
          owner_idx_d = pick_idx;
          gap_d       = '0;
        end
      end
      ST_OWN: begin
        if (release_owner) begin
          grant_d  = '0;
          gap_d    = '0;
          rr_ptr_d = (owner_idx_q == LAST_IDX) ? '0 : owner_idx_q + 1'b1;
        end else if (owner_vld) begin
          gap_d = '0;
        end else if (gap_q != '1) begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk48_i) begin
    if (rst_i) begin
      grant_q     <= '0;
      owner_idx_q <= '0;
      rr_ptr_q    <= '0;
      gap_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      grant_q     <= grant_d;
      owner_idx_q <= owner_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_q       <= gap_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign grant_o    = grant_q;
  assign busy_o     = (|grant_q) || tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte sources, an
// rs232out model busy 10 cycles per byte, and an in-order byte scoreboard.
// Latency/backpressure: bench only.
module tb_uart_tx_arbiter;

  localparam int N       = 3;
  localparam int MAX_GAP = 16;

  logic           clk48_i;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]   req_last_i;
  logic [N-1:0]   req_ready_o;
  logic           tx_valid_o;
  logic [7:0]     tx_data_o;
  logic           tx_ready_i;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  uart_tx_arbiter #(
    .N       (N),
    .MAX_GAP (MAX_GAP)
  ) dut (
    .clk48_i     (clk48_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  initial begin
    clk48_i = 1'b0;
    forever #5 clk48_i = ~clk48_i;
  end

  // Byte sources: {last, data} per entry.
  logic [8:0] src_buf [N][64];
  int         src_wr  [N];
  int         src_rd  [N];
  logic [7:0] exp_q   [$];
  int         n_chk;
  int         n_err;
  int         uart_cnt;
  bit         stall;
  bit         all_vld;
  bit [N-1:0] hs_req;
  bit         tx_hs;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (all_vld) begin
        req_valid_i[i]       = 1'b1;
        req_data_i[8*i +: 8] = 8'h00;
        req_last_i[i]        = 1'b0;
      end else if (src_rd[i] != src_wr[i]) begin
        e                    = src_buf[i][src_rd[i] & 63];
        req_valid_i[i]       = 1'b1;
        req_data_i[8*i +: 8] = e[7:0];
        req_last_i[i]        = e[8];
      end else begin
        req_valid_i[i]       = 1'b0;
        req_data_i[8*i +: 8] = 8'h00;
        req_last_i[i]        = 1'b0;
      end
    end
    tx_ready_i = (uart_cnt == 0) && !stall;
  endtask

  task automatic push_msg(input int r, input logic [7:0] base, input int len, input bit last_flag);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = base + 8'(k);
      src_buf[r][src_wr[r] & 63] = {(last_flag && (k == len - 1)), d};
      src_wr[r]++;
      exp_q.push_back(d);
    end
  endtask

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (src_rd[i] != src_wr[i]) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk48_i);
      if (srcs_empty() && exp_q.size() == 0 && !tx_valid_o && grant_o == '0) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk48_i);
    rst_i = 1'b1;
    @(negedge clk48_i);
    rst_i = 1'b0;
  endtask

  // Handshakes are decided at the negedge before the edge that performs them;
  // sources, rs232out model and input drive update just after that edge.
  initial begin
    logic [7:0] e;
    @(posedge clk48_i);
    forever begin
      @(negedge clk48_i);
      for (int i = 0; i < N; i++) hs_req[i] = req_valid_i[i] & req_ready_o[i] & !rst_i;
      tx_hs = tx_valid_o & tx_ready_i & !rst_i;
      if (tx_hs) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {24'd0, tx_data_o}, 32'h100);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {24'd0, tx_data_o}, {24'd0, e});
        end
      end
      @(posedge clk48_i);
      #1;
      for (int i = 0; i < N; i++) if (hs_req[i]) src_rd[i]++;
      if (tx_hs) uart_cnt = 10;
      else if (uart_cnt > 0) uart_cnt--;
      drive_inputs();
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit got;
    int n;
    int bad;
    n_chk    = 0;
    n_err    = 0;
    uart_cnt = 0;
    stall    = 1'b0;
    all_vld  = 1'b1;
    rst_i    = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    drive_inputs();

    // T1: reset held with every requester valid.
    @(posedge clk48_i);
    repeat (3) begin
      @(negedge clk48_i);
      chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
    end
    chk("rst_tx_data", 32'(tx_data_o), 32'd0);
    all_vld = 1'b0;
    @(negedge clk48_i);
    rst_i = 1'b0;

    // T2: single two-byte message from requester 0.
    push_msg(0, 8'h48, 1, 1'b0);
    push_msg(0, 8'h69, 1, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk48_i);
      if (req_valid_i[0] && req_ready_o[0]) begin
        chk("t2_grant_own", 32'(grant_o), 32'h1);
        if (req_last_i[0]) begin
          got = 1'b1;
          break;
        end
      end
    end
    chk("t2_last_seen", 32'(got), 32'd1);
    @(negedge clk48_i);
    chk("t2_grant_rel", 32'(grant_o), 32'd0);
    wait_drain("t2");

    // T3: atomic messages, round-robin order, pointer wraps back to 0.
    reset_pulse();
    push_msg(0, 8'h01, 3, 1'b1);
    push_msg(1, 8'h11, 2, 1'b1);
    push_msg(2, 8'h21, 2, 1'b1);
    wait_drain("t3");
    push_msg(0, 8'h05, 1, 1'b1);
    push_msg(1, 8'h15, 1, 1'b1);
    wait_drain("t3b");

    // T4: watchdog revokes a silent owner; waiting requester follows.
    reset_pulse();
    push_msg(1, 8'h31, 1, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk48_i);
      if (req_valid_i[1] && req_ready_o[1]) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4_accept", 32'(got), 32'd1);
    push_msg(2, 8'h41, 2, 1'b1);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk48_i);
      if (grant_o == 3'b010) n++;
      else break;
    end
    chk("t4_hold_cycles", 32'(n), 32'd16);
    chk("t4_revoked", 32'(grant_o), 32'd0);
    @(negedge clk48_i);
    chk("t4_next_grant", 32'(grant_o), 32'b100);
    wait_drain("t4");

    // T5: long UART backpressure with owner valid is not a stall.
    stall = 1'b1;
    push_msg(0, 8'h51, 3, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk48_i);
      if (tx_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("t5_loaded", 32'(got), 32'd1);
    bad = 0;
    repeat (50) begin
      @(negedge clk48_i);
      if (grant_o != 3'b001 || tx_data_o != 8'h51 || !tx_valid_o) bad++;
    end
    chk("t5_stable", 32'(bad), 32'd0);
    stall = 1'b0;
    wait_drain("t5");

    // T6: reset mid-message with a byte held; restart begins at requester 0.
    push_msg(1, 8'h61, 1, 1'b1);
    wait_drain("t6a");
    stall = 1'b1;
    push_msg(2, 8'h71, 4, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk48_i);
      if (tx_valid_o && grant_o == 3'b100) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6_midmsg", 32'(got), 32'd1);
    rst_i = 1'b1;
    @(negedge clk48_i);
    chk("t6_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("t6_tx_data", 32'(tx_data_o), 32'd0);
    chk("t6_grant", 32'(grant_o), 32'd0);
    chk("t6_req_ready", 32'(req_ready_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < N; i++) src_rd[i] = src_wr[i];
    exp_q.delete();
    @(negedge clk48_i);
    rst_i = 1'b0;
    stall = 1'b0;
    push_msg(0, 8'h81, 1, 1'b1);
    push_msg(1, 8'h91, 1, 1'b1);
    push_msg(2, 8'hA1, 1, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk48_i);
      if (grant_o != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6_first_grant", 32'(grant_o), 32'h1);
    chk("t6_grant_seen", 32'(got), 32'd1);
    wait_drain("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
